// File: rtl/stream_demux_pkg.sv
// Shared defaults for the registered stream demultiplexer and the helper
// that derives the select width from the channel count.
package stream_demux_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 8;
  localparam int DEF_DROP_W   = 8;

  // Channel counts need not be powers of two, so some select codes are out of range.
  function automatic int sel_width(input int channels);
    return (channels < 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demultiplexer channel; it can be
// reloaded on the same edge its current beat drains.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic             free,
  output logic [WIDTH-1:0] q
);

  assign free = !valid || ready;

  // The payload only moves on load, so a stalled beat stays bit-stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with unicast, broadcast and
// counted discard of beats whose select names no channel.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = sel_width(CHANNELS),
  parameter int DROP_W   = DEF_DROP_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [DROP_W-1:0]         drop_cnt,
  output logic                      err
);

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] load;
  logic                in_range;
  logic                accept;
  logic                drop;

  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = (in_sel == SEL_W'(i));
    end
  end

  assign in_range = |hit;

  // Held low in reset so no upstream handshake can complete while state is cleared.
  always_comb begin
    if (!rst_n) begin
      in_ready = 1'b0;
    end else if (in_bcast) begin
      in_ready = &free;
    end else if (in_range) begin
      in_ready = |(hit & free);
    end else begin
      in_ready = 1'b1;
    end
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !in_bcast && !in_range;

  always_comb begin
    load = '0;
    if (accept) begin
      load = in_bcast ? {CHANNELS{1'b1}} : hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= drop;
      if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .d     (in_data),
      .ready (out_ready[g]),
      .valid (out_valid[g]),
      .free  (free[g]),
      .q     (out_data[g*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Randomised and directed bench for stream_demux: an 8-channel instance is
// tracked by a per-channel behavioural model, a 6-channel instance covers drops.
module tb_stream_demux;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int N6 = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic [2:0]     in_sel;
  logic           in_bcast;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [7:0]     drop_cnt;
  logic           err;

  logic [W-1:0]    d6_in_data;
  logic [2:0]      d6_in_sel;
  logic            d6_in_bcast;
  logic            d6_in_valid;
  logic            d6_in_ready;
  logic [N6*W-1:0] d6_out_data;
  logic [N6-1:0]   d6_out_valid;
  logic [N6-1:0]   d6_out_ready;
  logic [7:0]      d6_drop_cnt;
  logic            d6_err;

  int vectors     = 0;
  int miscompares = 0;

  stream_demux #(.WIDTH(W), .CHANNELS(N), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt), .err(err)
  );

  stream_demux #(.WIDTH(W), .CHANNELS(N6), .DROP_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_data(d6_in_data), .in_sel(d6_in_sel),
    .in_bcast(d6_in_bcast), .in_valid(d6_in_valid), .in_ready(d6_in_ready),
    .out_data(d6_out_data), .out_valid(d6_out_valid), .out_ready(d6_out_ready),
    .drop_cnt(d6_drop_cnt), .err(d6_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: each channel is a one-deep mailbox.
  logic         m_valid [N];
  logic [W-1:0] m_data  [N];
  int           m_drops;
  logic         m_err;
  logic         m_acc;

  function automatic logic model_ready();
    logic all_free;
    if (!rst_n) return 1'b0;
    if (in_bcast) begin
      all_free = 1'b1;
      for (int c = 0; c < N; c++) if (m_valid[c] && !out_ready[c]) all_free = 1'b0;
      return all_free;
    end
    if (int'(in_sel) >= N) return 1'b1;
    return !m_valid[in_sel] || out_ready[in_sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_valid[c] = 1'b0;
        m_data[c]  = '0;
      end
      m_drops = 0;
      m_err   = 1'b0;
    end else begin
      m_acc = in_valid && model_ready();
      m_err = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (m_acc && (in_bcast || int'(in_sel) == c)) begin
          m_valid[c] = 1'b1;
          m_data[c]  = in_data;
        end else if (m_valid[c] && out_ready[c]) begin
          m_valid[c] = 1'b0;
        end
      end
      if (m_acc && !in_bcast && int'(in_sel) >= N) begin
        m_err = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < N; c++) begin
        checkOutput($sformatf("out_valid[%0d]", c), 32'(out_valid[c]), 32'(m_valid[c]));
        if (m_valid[c])
          checkOutput($sformatf("out_data[%0d]", c), 32'(out_data[c*W +: W]), 32'(m_data[c]));
      end
      checkOutput("in_ready", 32'(in_ready), 32'(model_ready()));
      checkOutput("err", 32'(err), 32'(m_err));
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] d, input logic [2:0] s,
                               input logic b, input logic v);
    in_data  = d;
    in_sel   = s;
    in_bcast = b;
    in_valid = v;
  endtask

  initial begin
    rst_n        = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0);
    out_ready    = '1;
    d6_in_data   = '0;
    d6_in_sel    = '0;
    d6_in_bcast  = 1'b0;
    d6_in_valid  = 1'b0;
    d6_out_ready = '1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset drop_cnt", 32'(drop_cnt), 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);
    checkOutput("reset d6 out_valid", 32'(d6_out_valid), 32'h0);

    $display("[TB] unicast sequence");
    applyStimulus(16'h0000, 3'd0, 1'b0, 1'b1);
    step();
    applyStimulus(16'hFEEF, 3'd7, 1'b0, 1'b1); #1;
    checkOutput("uni0 valid", 32'(out_valid), 32'h01);
    checkOutput("uni0 data", 32'(out_data[0*W +: W]), 32'h0000);
    step();
    applyStimulus(16'hFEEF, 3'd5, 1'b0, 1'b1); #1;
    checkOutput("uni7 valid", 32'(out_valid), 32'h80);
    checkOutput("uni7 data", 32'(out_data[7*W +: W]), 32'hFEEF);
    step();
    applyStimulus(16'h10AF, 3'd4, 1'b0, 1'b1); #1;
    checkOutput("uni5 valid", 32'(out_valid), 32'h20);
    checkOutput("uni5 data", 32'(out_data[5*W +: W]), 32'hFEEF);
    step();
    applyStimulus('0, '0, 1'b0, 1'b0); #1;
    checkOutput("uni4 valid", 32'(out_valid), 32'h10);
    checkOutput("uni4 data", 32'(out_data[4*W +: W]), 32'h10AF);
    step();
    checkOutput("uni drained", 32'(out_valid), 32'h0);

    $display("[TB] stall on channel 7");
    out_ready = 8'h7F;
    applyStimulus(16'hAAAA, 3'd7, 1'b0, 1'b1);
    step();
    applyStimulus(16'h5555, 3'd7, 1'b0, 1'b1); #1;
    checkOutput("stall in_ready", 32'(in_ready), 32'h0);
    checkOutput("stall valid", 32'(out_valid), 32'h80);
    step();
    checkOutput("stall hold data", 32'(out_data[7*W +: W]), 32'hAAAA);
    applyStimulus(16'h3333, 3'd3, 1'b0, 1'b1); #1;
    checkOutput("bypass in_ready", 32'(in_ready), 32'h1);
    step();
    applyStimulus(16'h5555, 3'd7, 1'b0, 1'b1);
    out_ready = 8'hFF; #1;
    checkOutput("release in_ready", 32'(in_ready), 32'h1);
    checkOutput("bypass valid", 32'(out_valid), 32'h88);
    checkOutput("bypass data", 32'(out_data[3*W +: W]), 32'h3333);
    step();
    applyStimulus('0, '0, 1'b0, 1'b0); #1;
    checkOutput("reload valid", 32'(out_valid), 32'h80);
    checkOutput("reload data", 32'(out_data[7*W +: W]), 32'h5555);
    step();

    $display("[TB] broadcast blocked by channel 2");
    out_ready = 8'hFB;
    applyStimulus(16'h2222, 3'd2, 1'b0, 1'b1);
    step();
    applyStimulus(16'h1234, 3'd0, 1'b1, 1'b1); #1;
    checkOutput("bcast blocked", 32'(in_ready), 32'h0);
    step();
    checkOutput("bcast no change valid", 32'(out_valid), 32'h04);
    checkOutput("bcast no change data", 32'(out_data[2*W +: W]), 32'h2222);
    out_ready = 8'hFF; #1;
    checkOutput("bcast unblocked", 32'(in_ready), 32'h1);
    step();
    applyStimulus('0, '0, 1'b0, 1'b0); #1;
    checkOutput("bcast all valid", 32'(out_valid), 32'hFF);
    for (int c = 0; c < N; c++)
      checkOutput($sformatf("bcast data[%0d]", c), 32'(out_data[c*W +: W]), 32'h1234);
    step();

    $display("[TB] drops on 6-channel instance");
    d6_in_sel = 3'd6; d6_in_valid = 1'b1; d6_in_data = 16'hDEAD; #1;
    checkOutput("drop in_ready", 32'(d6_in_ready), 32'h1);
    step();
    d6_in_sel = 3'd7; #1;
    checkOutput("drop1 err", 32'(d6_err), 32'h1);
    checkOutput("drop1 cnt", 32'(d6_drop_cnt), 32'h1);
    checkOutput("drop1 valid", 32'(d6_out_valid), 32'h0);
    step();
    d6_in_valid = 1'b0; #1;
    checkOutput("drop2 err", 32'(d6_err), 32'h1);
    checkOutput("drop2 cnt", 32'(d6_drop_cnt), 32'h2);
    checkOutput("drop2 valid", 32'(d6_out_valid), 32'h0);
    step();
    checkOutput("drop idle err", 32'(d6_err), 32'h0);
    checkOutput("drop idle cnt", 32'(d6_drop_cnt), 32'h2);
    d6_in_sel = 3'd5; d6_in_data = 16'hBEEF; d6_in_valid = 1'b1;
    step();
    d6_in_valid = 1'b0; #1;
    checkOutput("d6 ch5 valid", 32'(d6_out_valid), 32'h20);
    checkOutput("d6 ch5 data", 32'(d6_out_data[5*W +: W]), 32'hBEEF);
    d6_in_sel = 3'd6; d6_in_valid = 1'b1;
    repeat (300) step();
    d6_in_valid = 1'b0; #1;
    checkOutput("drop sat cnt", 32'(d6_drop_cnt), 32'hFF);
    checkOutput("drop sat err", 32'(d6_err), 32'h1);
    step();
    checkOutput("drop sat err clear", 32'(d6_err), 32'h0);

    $display("[TB] reset mid-operation");
    out_ready = 8'h00;
    applyStimulus(16'h1111, 3'd1, 1'b0, 1'b1);
    step();
    applyStimulus(16'h4444, 3'd4, 1'b0, 1'b1);
    step();
    applyStimulus('0, '0, 1'b0, 1'b0); #1;
    checkOutput("prefill valid", 32'(out_valid), 32'h12);
    rst_n = 1'b0; #1;
    checkOutput("async rst valid", 32'(out_valid), 32'h0);
    checkOutput("async rst data1", 32'(out_data[1*W +: W]), 32'h0);
    checkOutput("async rst data4", 32'(out_data[4*W +: W]), 32'h0);
    checkOutput("async rst d6 cnt", 32'(d6_drop_cnt), 32'h0);
    checkOutput("async rst in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = '1;
    step();

    $display("[TB] randomised traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(W'($urandom), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom | $urandom);
      step();
    end
    applyStimulus('0, '0, 1'b0, 1'b0);
    out_ready = '1;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
